// File: rtl/chiplet_dispatch.sv
// chiplet_dispatch: round-robin dispatch of workload packets over credited chiplets, with completions merged into a 2-entry FIFO
module chiplet_dispatch #(
    parameter int id_width_p     = 4,
    parameter int size_width_p   = 8,
    parameter int num_chiplets_p = 4,
    parameter int credits_p      = 2,
    parameter int width_p        = id_width_p + size_width_p,
    parameter int cred_w_p       = $clog2(credits_p + 1),
    parameter int tot_w_p        = $clog2(num_chiplets_p * credits_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              v_i,
    input  logic [width_p-1:0]                data_i,
    output logic                              ready_o,
    output logic [num_chiplets_p-1:0]         chip_v_o,
    output logic [width_p-1:0]                chip_data_o,
    input  logic [num_chiplets_p-1:0]         chip_ready_i,
    input  logic [num_chiplets_p-1:0]         ret_v_i,
    input  logic [num_chiplets_p*width_p-1:0] ret_data_i,
    output logic [num_chiplets_p-1:0]         ret_yumi_o,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    input  logic                              ready_i,
    output logic [tot_w_p-1:0]                outstanding_o,
    output logic                              idle_o
);
    localparam int ptr_w_lp = $clog2(num_chiplets_p);
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(num_chiplets_p - 1);

    logic [cred_w_p-1:0]       cred   [num_chiplets_p];
    logic [cred_w_p-1:0]       cred_n [num_chiplets_p];
    logic [ptr_w_lp-1:0]       disp_ptr, ret_ptr, sel, rsel;
    logic [num_chiplets_p-1:0] elig, sel_oh, rsel_oh;
    logic [width_p-1:0]        rdata;
    logic [width_p-1:0]        buf_mem [2];
    logic                      wr_ptr, rd_ptr, fire, space, accept, pop;
    logic [1:0]                cnt;
    logic [tot_w_p-1:0]        sum_n;

    // Both searches walk downward from ptr+N-1 to ptr so the closest match to ptr wins last.
    always_comb begin
        int d, r;
        d = 0;
        r = 0;
        sel = '0;
        sel_oh = '0;
        rsel = '0;
        rsel_oh = '0;
        rdata = '0;
        for (int k = 0; k < num_chiplets_p; k++)
            elig[k] = chip_ready_i[k] & (cred[k] < cred_w_p'(credits_p));
        for (int i = num_chiplets_p - 1; i >= 0; i--) begin
            d = (int'(disp_ptr) + i) % num_chiplets_p;
            r = (int'(ret_ptr) + i) % num_chiplets_p;
            if (elig[d]) begin
                sel = ptr_w_lp'(d);
                sel_oh = num_chiplets_p'(1) << d;
            end
            if (ret_v_i[r]) begin
                rsel = ptr_w_lp'(r);
                rsel_oh = num_chiplets_p'(1) << r;
                rdata = ret_data_i[r*width_p +: width_p];
            end
        end
    end

    assign ready_o     = (|elig) & ~reset_i;
    assign fire        = v_i & ready_o;
    assign chip_v_o    = fire ? sel_oh : '0;
    assign chip_data_o = data_i;
    assign v_o         = cnt != 2'd0;
    assign data_o      = buf_mem[rd_ptr];
    assign pop         = v_o & ready_i;
    assign space       = (cnt != 2'd2) | pop;
    assign accept      = (|ret_v_i) & space & ~reset_i;
    assign ret_yumi_o  = accept ? rsel_oh : '0;
    assign idle_o      = (outstanding_o == '0) & ~v_o;

    // A return from an empty counter is a protocol error and leaves it at zero.
    always_comb begin
        sum_n = '0;
        for (int k = 0; k < num_chiplets_p; k++) begin
            cred_n[k] = (chip_v_o[k] & ~ret_yumi_o[k]) ? cred[k] + 1'b1 :
                        (ret_yumi_o[k] & ~chip_v_o[k] & (cred[k] != '0)) ? cred[k] - 1'b1 : cred[k];
            sum_n = sum_n + tot_w_p'(cred_n[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_chiplets_p; k++)
                cred[k] <= '0;
            disp_ptr      <= '0;
            ret_ptr       <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            cnt           <= 2'd0;
            outstanding_o <= '0;
        end else begin
            for (int k = 0; k < num_chiplets_p; k++)
                cred[k] <= cred_n[k];
            outstanding_o <= sum_n;
            if (fire)
                disp_ptr <= (sel == last_lp) ? '0 : sel + 1'b1;
            if (accept) begin
                buf_mem[wr_ptr] <= rdata;
                wr_ptr          <= ~wr_ptr;
                ret_ptr         <= (rsel == last_lp) ? '0 : rsel + 1'b1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, accept} - {1'b0, pop};
        end
    end
endmodule
